// File: rtl/vid_prefetch_pkg.sv
// Display read-ahead: frame geometry and address helpers
// shared with the display controller.
package vid_prefetch_pkg;

  localparam int VID_ADR_W  = 18;
  localparam int VID_DATA_W = 32;
  localparam int VID_LINES  = 768;
  localparam int VID_WORDS  = 32;
  localparam int VID_DEPTH  = 8;
  localparam int VID_LINE_W = 10;
  localparam int VID_WORD_W = 5;

  localparam logic [VID_ADR_W-1:0] VID_ORG = 18'h37FC0;

  typedef logic [VID_ADR_W-1:0]  vid_adr_t;
  typedef logic [VID_DATA_W-1:0] vid_data_t;
  typedef logic [VID_LINE_W-1:0] vid_line_t;
  typedef logic [VID_WORD_W-1:0] vid_word_t;

  // Top line sits highest in memory, so lines descend.
  function automatic vid_adr_t vid_adr(
    input vid_adr_t  org,
    input vid_line_t line,
    input vid_word_t word
  );
    return org + {3'b000, ~line, word};
  endfunction

endpackage

// File: rtl/vid_fifo.sv
// Synchronous show-ahead FIFO for prefetched video words.
// Head word is visible combinationally; zero when empty.
module vid_fifo
  import vid_prefetch_pkg::*;
#(
  parameter int DEPTH = VID_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  vid_data_t       wdata,
  input  logic            pop,
  output vid_data_t       rdata,
  output logic [CW-1:0]   count
);

  vid_data_t      mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  assign rdata = (count == '0) ? '0 : mem[rp];

endmodule

// File: rtl/vid_prefetch.sv
// Frame read-ahead: walks the frame buffer, issues arbiter reads
// against FIFO credit and feeds the display controller.
module vid_prefetch
  import vid_prefetch_pkg::*;
#(
  parameter vid_adr_t ORG   = VID_ORG,
  parameter int       DEPTH = VID_DEPTH,
  parameter int       LINES = VID_LINES,
  parameter int       WORDS = VID_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  vid_req,
  output logic [VID_DATA_W-1:0] vid_data,
  output logic                  mem_req,
  output logic [VID_ADR_W-1:0]  mem_adr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [VID_DATA_W-1:0] mem_rdata,
  output logic                  underrun
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   LIMIT = DEPTH[CW:0];
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam vid_line_t LAST_LINE = VID_LINE_W'(LINES - 1);
  localparam vid_word_t LAST_WORD = VID_WORD_W'(WORDS - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] discard;
  logic [CW:0]   credit;
  vid_line_t     line;
  vid_word_t     word;
  logic          done;
  logic          adv;
  logic          keep;

  assign credit  = {1'b0, count} + {1'b0, outstanding};
  assign mem_req = ~done & ~rst & (credit < LIMIT);
  assign mem_adr = mem_req ? vid_adr(ORG, line, word) : '0;

  // A grant in the restart cycle belongs to the old frame.
  assign adv  = mem_gnt & mem_req & ~frame_start;
  assign keep = mem_rvalid & (discard == '0) & ~frame_start;

  assign out_next = outstanding + CW'(mem_gnt) - CW'(mem_rvalid);

  vid_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (keep),
    .wdata (mem_rdata),
    .pop   (vid_req),
    .rdata (vid_data),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
      line        <= '0;
      word        <= '0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (frame_start) begin
        line     <= '0;
        word     <= '0;
        done     <= 1'b0;
        underrun <= 1'b0;
        discard  <= out_next;
      end else begin
        if (mem_rvalid && discard != '0)
          discard <= discard - ONE;
        if (vid_req && count == '0)
          underrun <= 1'b1;
        if (adv) begin
          if (word == LAST_WORD) begin
            word <= '0;
            line <= line + VID_LINE_W'(1);
            if (line == LAST_LINE) done <= 1'b1;
          end else begin
            word <= word + VID_WORD_W'(1);
          end
        end
      end
    end
  end

endmodule
